// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request, response and memory-side bundle for the OTTER memory port arbiter
interface mem_port_arbiter_if;
    logic        FETCH_REQ;
    logic [31:0] FETCH_ADDR;
    logic        FETCH_GNT;
    logic        FETCH_VALID;
    logic [31:0] FETCH_RDATA;

    logic        DATA_REQ;
    logic        DATA_WE;
    logic [31:0] DATA_ADDR;
    logic [31:0] DATA_WDATA;
    logic [1:0]  DATA_SIZE;
    logic        DATA_SIGN;
    logic        DATA_GNT;
    logic        DATA_VALID;
    logic [31:0] DATA_RDATA;

    logic        PRG_HOLD;
    logic        PRG_WE;
    logic [31:0] PRG_ADDR;
    logic [31:0] PRG_WDATA;
    logic        PRG_GNT;

    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_RDATA;

    logic        PIPE_STALL;

    modport slave (
        input  FETCH_REQ, FETCH_ADDR,
        output FETCH_GNT, FETCH_VALID, FETCH_RDATA,
        input  DATA_REQ, DATA_WE, DATA_ADDR, DATA_WDATA, DATA_SIZE, DATA_SIGN,
        output DATA_GNT, DATA_VALID, DATA_RDATA,
        input  PRG_HOLD, PRG_WE, PRG_ADDR, PRG_WDATA,
        output PRG_GNT,
        output MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, MEM_SIZE, MEM_SIGN,
        input  MEM_RDATA,
        output PIPE_STALL
    );

    modport master (
        output FETCH_REQ, FETCH_ADDR,
        input  FETCH_GNT, FETCH_VALID, FETCH_RDATA,
        output DATA_REQ, DATA_WE, DATA_ADDR, DATA_WDATA, DATA_SIZE, DATA_SIGN,
        input  DATA_GNT, DATA_VALID, DATA_RDATA,
        output PRG_HOLD, PRG_WE, PRG_ADDR, PRG_WDATA,
        input  PRG_GNT,
        input  MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, MEM_SIZE, MEM_SIGN,
        output MEM_RDATA,
        input  PIPE_STALL
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for programmer, data and fetch with tagged 1-cycle read return
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input logic                CLK,
    input logic                RST,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PROG   = 2'd1;
    localparam logic [1:0] ST_RESUME = 2'd2;

    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_FETCH = 2'd1;
    localparam logic [1:0] TAG_DATA  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] fetch_wait_q, fetch_wait_d;
    logic [1:0] tag_q, tag_d;

    logic fetch_gnt, data_gnt, prg_gnt;
    logic fetch_first;

    always_comb begin
        fetch_gnt   = 1'b0;
        data_gnt    = 1'b0;
        prg_gnt     = 1'b0;
        fetch_first = (fetch_wait_q == 4'(MAX_WAIT));
        if (state_q == ST_RUN) begin
            if (bus.FETCH_REQ && (fetch_first || !bus.DATA_REQ)) begin
                fetch_gnt = 1'b1;
            end else if (bus.DATA_REQ) begin
                data_gnt = 1'b1;
            end
        end else if (state_q == ST_PROG) begin
            prg_gnt = bus.PRG_WE;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_wait_d = fetch_wait_q;
        case (state_q)
            ST_RUN: begin
                if (bus.PRG_HOLD) begin
                    state_d      = ST_PROG;
                    fetch_wait_d = 4'd0;
                end else if (fetch_gnt) begin
                    fetch_wait_d = 4'd0;
                end else if (bus.FETCH_REQ && (fetch_wait_q != 4'(MAX_WAIT))) begin
                    fetch_wait_d = fetch_wait_q + 4'd1;
                end
            end
            ST_PROG: begin
                if (!bus.PRG_HOLD) begin
                    state_d = ST_RESUME;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Only reads are tagged; writes never produce a response.
    always_comb begin
        tag_d = TAG_NONE;
        if (fetch_gnt) begin
            tag_d = TAG_FETCH;
        end else if (data_gnt && !bus.DATA_WE) begin
            tag_d = TAG_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RUN;
            fetch_wait_q <= 4'd0;
            tag_q        <= TAG_NONE;
        end else begin
            state_q      <= state_d;
            fetch_wait_q <= fetch_wait_d;
            tag_q        <= tag_d;
        end
    end

    always_comb begin
        bus.MEM_ADDR  = 32'd0;
        bus.MEM_WDATA = 32'd0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_RE    = 1'b0;
        bus.MEM_SIZE  = 2'b00;
        bus.MEM_SIGN  = 1'b0;
        if (fetch_gnt) begin
            bus.MEM_ADDR = bus.FETCH_ADDR;
            bus.MEM_RE   = 1'b1;
            bus.MEM_SIZE = 2'b10;
        end else if (data_gnt) begin
            bus.MEM_ADDR  = bus.DATA_ADDR;
            bus.MEM_WDATA = bus.DATA_WDATA;
            bus.MEM_WE    = bus.DATA_WE;
            bus.MEM_RE    = !bus.DATA_WE;
            bus.MEM_SIZE  = bus.DATA_SIZE;
            bus.MEM_SIGN  = bus.DATA_SIGN;
        end else if (prg_gnt) begin
            bus.MEM_ADDR  = bus.PRG_ADDR;
            bus.MEM_WDATA = bus.PRG_WDATA;
            bus.MEM_WE    = 1'b1;
            bus.MEM_SIZE  = 2'b10;
        end
    end

    assign bus.FETCH_GNT   = fetch_gnt;
    assign bus.DATA_GNT    = data_gnt;
    assign bus.PRG_GNT     = prg_gnt;
    assign bus.FETCH_VALID = (tag_q == TAG_FETCH);
    assign bus.DATA_VALID  = (tag_q == TAG_DATA);
    assign bus.FETCH_RDATA = (tag_q == TAG_FETCH) ? bus.MEM_RDATA : 32'd0;
    assign bus.DATA_RDATA  = (tag_q == TAG_DATA)  ? bus.MEM_RDATA : 32'd0;

    assign bus.PIPE_STALL = (state_q != ST_RUN) ||
                            (bus.FETCH_REQ && !fetch_gnt) ||
                            (bus.DATA_REQ && !data_gnt);
endmodule
